serial_subtractor: RTL

//  Bit-serial W-bit subtractor: accepts operands A, B over a valid/ready handshake,

---
 rtl/serial_subtractor_pkg.sv | 12 +
 rtl/serial_subtractor_bit.sv | 13 +
 rtl/serial_subtractor.sv | 124 ++++++++++++
 3 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and default width.
package sub_pkg;

  localparam int unsigned SUB_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_subtractor_bit.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow-out.
module full_subtractor_bit (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);

  assign d_o    = a_i ^ b_i ^ bin_i;
  assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor: DIFF = A - B computed LSB first, one bit per clock,
// with borrow-out and zero flag held on the output until the consumer accepts it.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int W = SUB_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_diff,
  output logic         out_borrow,
  output logic         out_zero,
  output logic [1:0]   dbg_state_o
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high; in_ready is high only in IDLE and out_valid only in DONE, both decoded
  // from the state register so reset clears them immediately.

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  state_e         state_q,  state_d;
  logic [W-1:0]   a_q,      a_d;
  logic [W-1:0]   b_q,      b_d;
  logic [W-1:0]   diff_q,   diff_d;
  logic           borrow_q, borrow_d;
  logic           zero_q,   zero_d;
  logic [CW-1:0]  cnt_q,    cnt_d;

  logic           bit_d;
  logic           bit_bout;
  logic [W-1:0]   diff_shifted;

  full_subtractor_bit u_fsb (
    .a_i    (a_q[0]),
    .b_i    (b_q[0]),
    .bin_i  (borrow_q),
    .d_o    (bit_d),
    .bout_o (bit_bout)
  );

  assign diff_shifted = {bit_d, diff_q[W-1:1]};

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    diff_d    = diff_q;
    borrow_d  = borrow_q;
    zero_d    = zero_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d      = in_a;
          b_d      = in_b;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        diff_d   = diff_shifted;
        borrow_d = bit_bout;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          // Last bit: the zero flag must see the fully assembled difference.
          zero_d  = (diff_shifted == '0);
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_diff    = diff_q;
  assign out_borrow  = borrow_q;
  assign out_zero    = zero_q;
  assign dbg_state_o = state_q;

endmodule
